// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data refill memory-port arbiter.
// State encoding, requester IDs and line geometry helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam int DEF_LINE_WORDS = 4;
    localparam int LINE_BYTES     = DEF_LINE_WORDS * 4;
    localparam int OFFSET_BITS    = $clog2(LINE_BYTES);

    // Byte-offset width of a line holding 'words' 32-bit words.
    function automatic int offset_bits(input int words);
        return $clog2(words * 4);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_addr_gen.sv
// Beat counter plus latched line base; produces the word byte address of the
// current beat and flags the final beat of the line.
module burst_addr_gen
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_beat
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = offset_bits(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] base_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat   <= '0;
            base_q <= '0;
        end else if (load) begin
            base_q <= base & ~OFF_MASK;
            beat   <= '0;
        end else if (advance) begin
            beat <= last_beat ? '0 : beat + BEAT_W'(1);
        end
    end

    // Offset stays inside the line, so the sum never carries into the next line.
    assign addr      = base_q + ADDR_W'({beat, 2'b00});
    assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-word memory port between the
// I-side refill (read only) and the D-side refill/writeback bursts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state, state_nxt;
    req_id_e           last_grant, last_grant_nxt;
    logic              we_q, we_nxt;
    logic              i_elig, d_elig;
    logic              load;
    logic [ADDR_W-1:0] load_base;
    logic              beat_done;
    logic              last_beat;
    logic [ADDR_W-1:0] gen_addr;

    // A requester's own done cycle must not look like a fresh request.
    assign i_elig    = i_req && !i_done;
    assign d_elig    = d_req && !d_done;
    assign beat_done = (state != IDLE) && mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ_I;
            we_q       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            we_q       <= we_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        we_nxt         = we_q;
        load           = 1'b0;
        load_base      = i_addr;
        case (state)
            IDLE: begin
                if (d_elig && (!i_elig || last_grant == REQ_I)) begin
                    state_nxt      = GRANT_D;
                    last_grant_nxt = REQ_D;
                    we_nxt         = d_we;
                    load           = 1'b1;
                    load_base      = d_addr;
                end else if (i_elig) begin
                    state_nxt      = GRANT_I;
                    last_grant_nxt = REQ_I;
                    we_nxt         = 1'b0;
                    load           = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                if (beat_done && last_beat)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    burst_addr_gen #(
        .LINE_WORDS(LINE_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .base     (load_base),
        .advance  (beat_done),
        .addr     (gen_addr),
        .last_beat(last_beat)
    );

    assign busy      = (state != IDLE);
    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = busy ? gen_addr : '0;
    assign mem_wdata = (state == GRANT_D && we_q) ? d_wdata : '0;
    assign d_wready  = (state == GRANT_D) && we_q && mem_ready;

    // Read data is returned one cycle after its beat; done lines up with the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_done   <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_done   <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            if (beat_done && !we_q) begin
                if (state == GRANT_I) begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= mem_rdata;
                end else begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= mem_rdata;
                end
            end
            if (beat_done && last_beat) begin
                if (state == GRANT_I) i_done <= 1'b1;
                else                  d_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: line-burst table, directed corner sequences and
// random traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LW = 4;
    localparam logic [31:0] LMASK = 32'(LW * 4 - 1);

    logic        clk, rst;
    logic        i_req, i_rvalid, i_done;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_wready, d_rvalid, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: bound expired waiting on DUT", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: owner + beats-completed per burst
    int          m_owner;   // 0 none, 1 I, 2 D
    int          m_beats;
    int          m_last;    // side granted most recently
    bit          m_wr;
    logic [31:0] m_base;
    bit          e_irv, e_idone, e_drv, e_ddone;
    logic [31:0] e_ird, e_drd;
    bit          m_ie, m_de;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= 0; m_beats <= 0; m_last <= 1; m_wr <= 0; m_base <= '0;
            e_irv <= 0; e_idone <= 0; e_drv <= 0; e_ddone <= 0; e_ird <= '0; e_drd <= '0;
        end else begin
            e_irv <= 0; e_drv <= 0; e_idone <= 0; e_ddone <= 0;
            if (m_owner != 0) begin
                if (mem_ready) begin
                    if (!m_wr && m_owner == 1) begin e_irv <= 1; e_ird <= mem_rdata; end
                    if (!m_wr && m_owner == 2) begin e_drv <= 1; e_drd <= mem_rdata; end
                    if (m_beats == LW - 1) begin
                        m_owner <= 0;
                        m_beats <= 0;
                        if (m_owner == 1) e_idone <= 1; else e_ddone <= 1;
                    end else begin
                        m_beats <= m_beats + 1;
                    end
                end
            end else begin
                m_ie = i_req && !e_idone;
                m_de = d_req && !e_ddone;
                if (m_de && (!m_ie || m_last == 1)) begin
                    m_owner <= 2; m_last <= 2; m_wr <= d_we; m_base <= d_addr & ~LMASK; m_beats <= 0;
                end else if (m_ie) begin
                    m_owner <= 1; m_last <= 1; m_wr <= 0; m_base <= i_addr & ~LMASK; m_beats <= 0;
                end
            end
        end
    end

    logic [135:0] m_act, m_exp;
    always @(negedge clk) begin
        if (!rst) begin
            m_act = {mem_req, mem_we, mem_addr, mem_wdata, d_wready, busy,
                     i_rvalid, i_rdata, i_done, d_rvalid, d_rdata, d_done};
            m_exp = {m_owner != 0, m_owner != 0 && m_wr,
                     (m_owner != 0) ? m_base + 32'(m_beats * 4) : 32'h0,
                     (m_owner == 2 && m_wr) ? d_wdata : 32'h0,
                     m_owner == 2 && m_wr && mem_ready, m_owner != 0,
                     e_irv, e_ird, e_idone, e_drv, e_drd, e_ddone};
            nvec++;
            if (m_act !== m_exp) begin
                nerr++;
                $display("FAIL model_cycle t=%0t: got %h expected %h", $time, m_act, m_exp);
            end
        end
    end

    // ---------------- helpers
    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (!busy && !i_done && !d_done) ok = 1;
        end
        if (!ok) timeout(nm);
    endtask

    task automatic do_reset();
        i_req = 0; d_req = 0; d_we = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] e_first;
        logic [31:0] e_last;
    } vec_t;

    task automatic run_burst(input vec_t v, input int idx);
        bit got_done = 0, rv_at_done = 0;
        int nb = 0, nx = 0;
        logic [31:0] first = '0, last = '0;
        wait_idle("idle_before_burst");
        mem_ready = 1;
        if (v.is_d) begin d_req = 1; d_we = v.we; d_addr = v.addr; end
        else        begin i_req = 1; i_addr = v.addr; end
        for (int c = 0; c < 40 && !got_done; c++) begin
            d_wdata = $urandom; mem_rdata = $urandom;
            @(negedge clk);
            if (mem_req && mem_ready) begin
                if (nb == 0) first = mem_addr;
                last = mem_addr;
                nb++;
            end
            if (v.is_d ? d_rvalid : i_rvalid) nx++;
            if (v.is_d && d_wready) nx++;
            if (v.is_d ? d_done : i_done) begin
                got_done = 1;
                rv_at_done = v.is_d ? d_rvalid : i_rvalid;
            end
            step();
            if (got_done) begin i_req = 0; d_req = 0; d_we = 0; end
        end
        if (!got_done) timeout($sformatf("burst%0d_done", idx));
        chk($sformatf("burst%0d_first_addr", idx), first, v.e_first);
        chk($sformatf("burst%0d_last_addr", idx), last, v.e_last);
        chk($sformatf("burst%0d_beats", idx), nb, LW);
        chk($sformatf("burst%0d_xfers", idx), nx, LW);
        chk($sformatf("burst%0d_rvalid_with_done", idx), rv_at_done, !v.we);
    endtask

    // ---------------- main sequence
    vec_t        tbl[5];
    bit          pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [31:0] pat_addr[7] = '{32'h2000, 32'h2004, 32'h2004, 32'h2004, 32'h2008, 32'h200C, 32'h200C};
    bit          order[4];
    int          gap[4];
    bit          stop;

    initial begin
        rst = 1; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0;
        d_wdata = '0; mem_ready = 0; mem_rdata = '0; stop = 0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_regs", {i_rvalid, i_done, d_rvalid, d_done, d_wready, mem_req}, 0);
        @(negedge clk); @(negedge clk); rst = 0;

        tbl[0] = '{0, 0, 32'h0000_0104, 32'h0000_0100, 32'h0000_010C};
        tbl[1] = '{1, 1, 32'h0000_2008, 32'h0000_2000, 32'h0000_200C};
        tbl[2] = '{1, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFFC};
        tbl[3] = '{0, 0, 32'h8000_003F, 32'h8000_0030, 32'h8000_003C};
        tbl[4] = '{1, 0, 32'h1234_567B, 32'h1234_5670, 32'h1234_567C};
        for (int k = 0; k < 5; k++) run_burst(tbl[k], k);

        // Tie after reset, then continuous re-requests: D,I,D,I with one idle cycle between.
        begin
            int ng = 0, idle_run = 0;
            bit prev_busy = 0, dn_i, dn_d, fin = 0;
            do_reset();
            i_req = 1; d_req = 1; i_addr = 32'h1000; d_addr = 32'h3000; d_we = 0; mem_ready = 1;
            for (int c = 0; c < 80 && !fin; c++) begin
                @(negedge clk);
                if (busy && !prev_busy) begin
                    if (ng < 4) begin order[ng] = (mem_addr == 32'h3000); gap[ng] = idle_run; end
                    ng++;
                end
                idle_run = busy ? 0 : idle_run + 1;
                prev_busy = busy;
                dn_i = i_done; dn_d = d_done;
                step();
                if (ng >= 4) stop = 1;
                if (stop && dn_i) i_req = 0;
                if (stop && dn_d) d_req = 0;
                if (stop && !i_req && !d_req && !busy) fin = 1;
            end
            if (!fin) timeout("rr_sequence");
            chk("rr_count", ng >= 4, 1);
            for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d_is_d", k), order[k], (k % 2 == 0));
            for (int k = 1; k < 4; k++) chk($sformatf("rr_gap%0d", k), gap[k], 1);
            stop = 0;
        end

        // Write burst with a stalling memory.
        wait_idle("idle_before_write");
        d_req = 1; d_we = 1; d_addr = 32'h2000; mem_ready = 0;
        step();
        for (int p = 0; p < 7; p++) begin
            mem_ready = pat[p]; d_wdata = $urandom;
            @(negedge clk);
            chk($sformatf("wr_wready%0d", p), d_wready, pat[p]);
            chk($sformatf("wr_addr%0d", p), mem_addr, pat_addr[p]);
            chk($sformatf("wr_wdata%0d", p), mem_wdata, d_wdata);
            step();
        end
        mem_ready = 0;
        @(negedge clk);
        chk("wr_done", d_done, 1);
        step();
        d_req = 0; d_we = 0;

        // Asynchronous reset mid-read, then restart from the line base.
        begin
            bit got_done = 0;
            int nrv = 0;
            wait_idle("idle_before_abort");
            i_req = 1; i_addr = 32'h0000_0508; mem_ready = 1;
            repeat (3) @(negedge clk);
            #2 rst = 1;
            #1;
            chk("abort_mem_req", mem_req, 0);
            chk("abort_busy", busy, 0);
            chk("abort_rvalid", i_rvalid, 0);
            @(negedge clk); rst = 0;
            @(negedge clk);
            chk("restart_addr", mem_addr, 32'h0000_0500);
            chk("restart_no_done", i_done, 0);
            for (int c = 0; c < 20 && !got_done; c++) begin
                if (i_rvalid) nrv++;
                if (i_done) got_done = 1;
                step();
                if (got_done) i_req = 0;
                else @(negedge clk);
            end
            if (!got_done) timeout("restart_done");
            chk("restart_rvalid_count", nrv, LW);
        end

        // Random traffic under the requester contract.
        for (int c = 0; c < 2500 || i_req || d_req || busy; c++) begin
            if (c >= 2500) stop = 1;
            if (c > 3000) begin timeout("random_drain"); break; end
            step();
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = $urandom;
            d_wdata = $urandom;
            if (!i_req) begin
                if (!stop && $urandom_range(0, 2) == 0) begin i_req = 1; i_addr = $urandom; end
            end else if (i_done) begin
                i_req = !stop && ($urandom_range(0, 1) == 1); i_addr = $urandom;
            end
            if (!d_req) begin
                if (!stop && $urandom_range(0, 2) == 0) begin
                    d_req = 1; d_addr = $urandom; d_we = $urandom_range(0, 1);
                end
            end else if (d_done) begin
                d_req = !stop && ($urandom_range(0, 1) == 1);
                d_addr = $urandom; d_we = $urandom_range(0, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported backing-memory word interface between two burst requesters: the instruction-fetch refill (I-side, read-only) and the data cache refill/writeback (D-side, read or write).
- Sits below the fetch path and the data cache, and above the memory model.
- Each grant moves one full cache line as LINE_WORDS single-word beats. Grants are round-robin.

Parameters:
- LINE_WORDS, 4, beats per burst (power of 2, ≥2)
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- i_req  in  1  I-side burst request; held until i_done
- i_addr  in  ADDR_W  I-side line address; low log2(LINE_WORDS*4) bits ignored
- i_rdata  out  DATA_W  I-side read word
- i_rvalid  out  1  i_rdata valid
- i_done  out  1  I-side burst complete
- d_req  in  1  D-side burst request; held until d_done
- d_we  in  1  D-side burst is a write; stable while d_req
- d_addr  in  ADDR_W  D-side line address; low bits ignored as for i_addr
- d_wdata  in  DATA_W  current write word
- d_wready  out  1  write beat accepted; requester advances d_wdata
- d_rdata  out  DATA_W  D-side read word
- d_rvalid  out  1  d_rdata valid
- d_done  out  1  D-side burst complete
- mem_req  out  1  beat request to memory
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  word byte address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory completes current beat this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ready && !mem_we
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, GRANT_I, GRANT_D.
- Registers:
  - state
  - beat counter (log2(LINE_WORDS) bits)
  - latched base address
  - latched we
  - last_grant (I/D)
- Reset (async, rst=1): state=IDLE, beat=0, last_grant=I.
  - All registered outputs are 0: i_rvalid, i_rdata, i_done, d_rvalid, d_rdata, d_done.
  - All combinational outputs are forced to 0: mem_req, mem_we, mem_addr, mem_wdata, d_wready, busy.
  - Reset mid-burst abandons the burst. No done is issued. The requester re-requests.
- IDLE arbitration uses eligible requests: i_elig = i_req && !i_done; d_elig = d_req && !d_done. This masks the requester's still-high req during its own done cycle.
  - Only one eligible: grant it.
  - Both eligible: grant the one that is not last_grant. After reset, D wins the first tie.
  - On grant:
    - Latch base = addr with low bits cleared.
    - Latch we (d_we for D, 0 for I).
    - beat=0.
    - last_grant = granted side.
- GRANT_x:
  - mem_req=1, mem_we=latched we, mem_addr=base + beat*4. Address arithmetic is modulo 2^ADDR_W.
  - mem_wdata = d_wdata when GRANT_D && we, else 0.
  - On a cycle with mem_ready=1, the beat completes:
    - beat increments.
    - Write burst: d_wready=1 in the same cycle (combinational).
    - Read burst: next cycle x_rvalid=1 and x_rdata = the captured mem_rdata.
  - On the last beat (beat==LINE_WORDS-1 && mem_ready): next cycle x_done=1 (1-cycle pulse), state=IDLE, beat=0. For reads, x_done coincides with the final x_rvalid.
  - mem_ready=0: all outputs hold; no rvalid/wready; the address does not advance.
- The other requester's rdata/rvalid/wready/done stay 0 throughout.
- Minimum occupancy: LINE_WORDS cycles plus 1 IDLE cycle between grants. There is no back-to-back grant without IDLE.
- Requester contract: drop req in the cycle after done, unless it immediately issues a new burst.
  - A req still high in the done cycle is masked.
  - A req high the following cycle is a new request.
- Signals ignored outside their use:
  - mem_ready in IDLE.
  - d_we/d_addr/i_addr changes during a grant (latched values are used).

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE/GRANT_I/GRANT_D)
  - requester ID constants (REQ_I=0, REQ_D=1)
  - LINE_BYTES and OFFSET_BITS derived from LINE_WORDS
- One sub-module, burst_addr_gen:
  - Holds the beat counter and base register.
  - Inputs: load, base, advance.
  - Outputs: word address, last_beat.

Test Plan:
1. i_req=1, i_addr=0x0000_0104, mem_ready tied 1 → mem_addr 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles with mem_we=0. i_rvalid for 4 cycles, each 1 cycle after its beat, carrying the mem_rdata values. i_done pulses with the 4th i_rvalid. busy drops afterwards.
2. After reset, i_req and d_req rise in the same cycle → D granted first. I granted in the cycle after the IDLE cycle that follows d_done. No I-side outputs toggle during the D burst.
3. Both requesters re-request immediately after each done, 4 bursts total → grants go D, I, D, I. There is exactly one IDLE cycle between bursts, and the done-cycle masking causes no spurious regrant.
4. D write, d_addr=0x2000, mem_ready pattern 1,0,0,1,1,0,1 → d_wready = 1,0,0,1,1,0,1. mem_addr advances 0x2000→0x200C only on ready. mem_wdata tracks d_wdata. d_done 1 cycle after the 7th cycle.
5. rst asserted asynchronously after beat 2 of an I read → mem_req, busy and i_rvalid go 0 immediately. After release with i_req still high, the burst restarts at the base address with beat 0 and no i_done from the aborted burst.
6. D read at 0xFFFF_FFF0 with mem_ready=1 → addresses 0xFFFF_FFF0..0xFFFF_FFFC. No wrap inside the line. The beat counter returns to 0 and d_done asserts.
